// File: rtl/linebuf_cmd_ctrl.sv
// Command sequencer feeding the line-buffer BRAM write port.
// Decodes SET_ADDR / WRITE / FILL byte streams into write strobes.
module linebuf_cmd_ctrl #(
  parameter int          ADDR_W      = 8,
  parameter logic [7:0]  OP_SET_ADDR = 8'h01,
  parameter logic [7:0]  OP_WRITE    = 8'h02,
  parameter logic [7:0]  OP_FILL     = 8'h03
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cmd_avail,
  input  logic [7:0]        cmd_data,
  output logic              cmd_rd,
  output logic              linebuf_wr,
  output logic [ADDR_W-1:0] linebuf_wr_addr,
  output logic [15:0]       linebuf_wr_data,
  output logic              busy,
  output logic              bad_cmd
);

  typedef enum logic [2:0] {
    S_OP, S_ADDR, S_CNT, S_LO, S_HI, S_WR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [8:0]        cnt;
  logic [15:0]       data;
  logic              fill;
  logic              take;

  // A byte is never sampled in its own acknowledge cycle.
  assign take = cmd_avail && !cmd_rd && (state != S_WR);
  assign busy = (state != S_OP) || cmd_rd;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= S_OP;
      addr            <= '0;
      cnt             <= '0;
      data            <= '0;
      fill            <= 1'b0;
      cmd_rd          <= 1'b0;
      bad_cmd         <= 1'b0;
      linebuf_wr      <= 1'b0;
      linebuf_wr_addr <= '0;
      linebuf_wr_data <= '0;
    end else begin
      cmd_rd     <= take;
      bad_cmd    <= 1'b0;
      linebuf_wr <= 1'b0;
      if (state == S_WR) begin
        addr <= addr + 1'b1;
        cnt  <= cnt - 9'd1;
        if (fill && cnt != 9'd1) begin
          linebuf_wr      <= 1'b1;
          linebuf_wr_addr <= addr + 1'b1;
        end else begin
          state <= S_OP;
        end
      end else if (take) begin
        unique case (state)
          S_OP: begin
            unique case (1'b1)
              (cmd_data == 8'h00):       state <= S_OP;
              (cmd_data == OP_SET_ADDR): state <= S_ADDR;
              (cmd_data == OP_WRITE): begin
                fill  <= 1'b0;
                state <= S_LO;
              end
              (cmd_data == OP_FILL):     state <= S_CNT;
              default:                   bad_cmd <= 1'b1;
            endcase
          end
          S_ADDR: begin
            addr  <= ADDR_W'(cmd_data);
            state <= S_OP;
          end
          S_CNT: begin
            cnt   <= (cmd_data == 8'h00) ? 9'd256 : {1'b0, cmd_data};
            fill  <= 1'b1;
            state <= S_LO;
          end
          S_LO: begin
            data[7:0] <= cmd_data;
            state     <= S_HI;
          end
          S_HI: begin
            data[15:8]      <= cmd_data;
            linebuf_wr      <= 1'b1;
            linebuf_wr_addr <= addr;
            linebuf_wr_data <= {cmd_data, data[7:0]};
            state           <= S_WR;
          end
          default: state <= S_OP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_linebuf_cmd_ctrl.sv
// Bench for linebuf_cmd_ctrl: directed and random command streams
// checked against a command-level model of the line-buffer writes.
module tb_linebuf_cmd_ctrl;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        cmd_avail = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_rd;
  logic        linebuf_wr;
  logic [7:0]  linebuf_wr_addr;
  logic [15:0] linebuf_wr_data;
  logic        busy;
  logic        bad_cmd;

  linebuf_cmd_ctrl dut (
    .clk(clk),
    .nrst(nrst),
    .cmd_avail(cmd_avail),
    .cmd_data(cmd_data),
    .cmd_rd(cmd_rd),
    .linebuf_wr(linebuf_wr),
    .linebuf_wr_addr(linebuf_wr_addr),
    .linebuf_wr_data(linebuf_wr_data),
    .busy(busy),
    .bad_cmd(bad_cmd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
    int          c;
  } wr_t;

  int   cyc = 0;
  wr_t  obs[$];
  int   rd_q[$];
  int   rd_b2b = 0;
  int   bad_seen = 0;
  int   busy_viol = 0;
  logic prev_rd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (linebuf_wr)
      obs.push_back('{linebuf_wr_addr, linebuf_wr_data, cyc});
    if (cmd_rd) rd_q.push_back(cyc);
    if (cmd_rd && prev_rd) rd_b2b <= rd_b2b + 1;
    if (bad_cmd) bad_seen <= bad_seen + 1;
    if (linebuf_wr && !busy) busy_viol <= busy_viol + 1;
    prev_rd <= cmd_rd;
  end

  int         total = 0;
  int         bad = 0;
  logic [7:0] bytes[$];
  wr_t        expq[$];
  logic [7:0] maddr = 8'h00;
  int         mbad = 0;
  int         grp = 0;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    cmd_data  = b;
    cmd_avail = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_rd) begin
        got = 1;
        break;
      end
    end
    cmd_avail = 1'b0;
    if (!got) chk("rd_timeout", {31'd0, cmd_rd}, 32'd1);
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy && !linebuf_wr) begin
        idle = 1;
        break;
      end
    end
    if (!idle) chk("idle_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  // Command-level model: what the line buffer should receive.
  task automatic model_run();
    int i = 0;
    int n = bytes.size();
    int cnt;
    logic [7:0] op;
    expq.delete();
    while (i < n) begin
      op = bytes[i];
      i++;
      case (op)
        8'h00: ;
        8'h01: begin
          maddr = bytes[i];
          i++;
        end
        8'h02: begin
          expq.push_back('{maddr, {bytes[i+1], bytes[i]}, grp});
          maddr++;
          grp++;
          i += 2;
        end
        8'h03: begin
          cnt = (bytes[i] == 8'h00) ? 256 : int'(bytes[i]);
          for (int k = 0; k < cnt; k++) begin
            expq.push_back('{maddr, {bytes[i+2], bytes[i+1]}, grp});
            maddr++;
          end
          grp++;
          i += 3;
        end
        default: mbad++;
      endcase
    end
  endtask

  task automatic run_seq(input int gmax);
    int s0 = obs.size();
    int b0 = bad_seen;
    int m0 = mbad;
    int n;
    foreach (bytes[j]) begin
      repeat ($urandom_range(gmax, 0)) @(negedge clk);
      send_byte(bytes[j]);
    end
    wait_idle();
    model_run();
    n = obs.size() - s0;
    chk("wr_count", n, expq.size());
    if (n > expq.size()) n = expq.size();
    for (int k = 0; k < n; k++) begin
      chk("wr_addr", obs[s0+k].a, expq[k].a);
      chk("wr_data", obs[s0+k].d, expq[k].d);
      if (k > 0 && expq[k].c == expq[k-1].c)
        chk("wr_gap", obs[s0+k].c - obs[s0+k-1].c, 1);
    end
    chk("bad_cnt", bad_seen - b0, mbad - m0);
  endtask

  initial begin
    int s0;
    int r0;
    int nb;
    logic [7:0] op;

    repeat (2) @(negedge clk);
    chk("rst_wr", {31'd0, linebuf_wr}, 32'd0);
    chk("rst_rd", {31'd0, cmd_rd}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bad", {31'd0, bad_cmd}, 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // single WRITE, then a second to land at the advanced address
    r0 = rd_q.size();
    bytes = '{8'h02, 8'h34, 8'h12};
    run_seq(2);
    chk("t1_rd_pulses", rd_q.size() - r0, 3);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    bytes = '{8'h02, 8'h78, 8'h56};
    run_seq(0);

    // SET_ADDR then a wrapping FILL of 4
    bytes = '{8'h01, 8'hFE};
    run_seq(1);
    send_byte(8'h03);
    chk("t2_busy_op", {31'd0, busy}, 32'd1);
    bytes = '{8'h04, 8'hCD, 8'hAB};
    foreach (bytes[j]) send_byte(bytes[j]);
    wait_idle();
    bytes = '{8'h03, 8'h04, 8'hCD, 8'hAB};
    s0 = obs.size() - 4;
    model_run();
    for (int k = 0; k < 4; k++) begin
      chk("t2_addr", obs[s0+k].a, expq[k].a);
      chk("t2_data", obs[s0+k].d, expq[k].d);
    end
    chk("t2_span", obs[s0+3].c - obs[s0].c, 3);
    bytes = '{8'h02, 8'h11, 8'h22};
    run_seq(0);

    // FILL of 256 covers every address
    bytes = '{8'h01, 8'h40, 8'h03, 8'h00, 8'h55, 8'hAA};
    run_seq(1);
    bytes = '{8'h02, 8'h99, 8'h88};
    run_seq(0);

    // bad opcode, NOP, WRITE
    bytes = '{8'h7F, 8'h00, 8'h02, 8'h01, 8'h00};
    run_seq(2);

    // back-to-back bytes: one per two cycles
    r0 = rd_q.size();
    bytes = '{8'h00, 8'h01, 8'h05, 8'h00, 8'h02, 8'h11, 8'h22};
    run_seq(0);
    for (int k = 1; k < 7; k++)
      chk("stream_gap", rd_q[r0+k] - rd_q[r0+k-1], 2);

    // randomized command streams
    for (int r = 0; r < 5; r++) begin
      bytes.delete();
      for (int c = 0; c < 6; c++) begin
        nb = $urandom_range(9, 0);
        if (nb == 0) bytes.push_back(8'h00);
        else if (nb <= 2) begin
          bytes.push_back(8'h01);
          bytes.push_back(8'($urandom));
        end else if (nb <= 5) begin
          bytes.push_back(8'h02);
          bytes.push_back(8'($urandom));
          bytes.push_back(8'($urandom));
        end else if (nb <= 8) begin
          bytes.push_back(8'h03);
          bytes.push_back(8'($urandom_range(8, 1)));
          bytes.push_back(8'($urandom));
          bytes.push_back(8'($urandom));
        end else begin
          op = 8'($urandom_range(255, 4));
          bytes.push_back(op);
        end
      end
      run_seq(2);
    end

    // reset in the middle of an 8-word fill
    s0 = obs.size();
    bytes = '{8'h01, 8'h20, 8'h03, 8'h08, 8'h11, 8'h22};
    foreach (bytes[j]) send_byte(bytes[j]);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid_fill_wr", {31'd0, linebuf_wr}, 32'd1);
    #1 nrst = 1'b0;
    #1;
    chk("arst_wr", {31'd0, linebuf_wr}, 32'd0);
    chk("arst_rd", {31'd0, cmd_rd}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    #9 nrst = 1'b1;
    repeat (20) @(negedge clk);
    chk("arst_nwr", obs.size() - s0, 3);
    chk("arst_last", obs[obs.size()-1].a, 8'h22);
    maddr = 8'h00;
    bytes = '{8'h02, 8'hEF, 8'hBE};
    run_seq(1);

    chk("rd_b2b", rd_b2b, 0);
    chk("busy_viol", busy_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
